// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and access-fault check for the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [2:0] {IDLE, ACCESS, MERGE, RESP, ERR} lsu_state_t;
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'b11) || (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension for loads and lane merge for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    assign sh = {offset, 3'b000};
    assign shifted = word >> sh;
    assign load_data = size == SZ_BYTE ? {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]} :
                       size == SZ_HALF ? {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]} : word;
    assign lane_mask = size == SZ_BYTE ? 32'h0000_00ff : 32'h0000_ffff;
    assign store_data = size == SZ_WORD ? wdata : (word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the word-addressed data memory with sub-word RMW
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    lsu_state_t  state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic        fault;

    lsu_lane_align u_align (
        .word       (mem_read_data),
        .offset     (off_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .load_data  (ld_data),
        .store_data (st_data)
    );

    assign fault = access_fault(req_size, req_addr[1:0]) || ((req_addr >> 2) >= ADDR_W'(MEM_WORDS));
    // reset in the same cycle as a pending strobe must keep memory untouched
    assign mem_read  = mem_read_q && !rst;
    assign mem_write = mem_write_q && !rst;

    // request FSM with registered strobes and response
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            wr_q           <= 1'b0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            off_q          <= '0;
            wdata_q        <= '0;
        end else begin
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_rdata  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    wr_q      <= req_write;
                    size_q    <= req_size;
                    uns_q     <= req_unsigned;
                    off_q     <= req_addr[1:0];
                    wdata_q   <= req_wdata;
                    req_ready <= 1'b0;
                    if (fault) begin
                        state      <= ERR;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                    end else begin
                        state          <= ACCESS;
                        mem_address    <= req_addr >> 2;
                        mem_write_data <= req_wdata;
                        mem_read_q     <= !req_write || req_size != SZ_WORD;
                        mem_write_q    <= req_write && req_size == SZ_WORD;
                    end
                end
                ACCESS: if (wr_q && size_q != SZ_WORD) begin
                    state          <= MERGE;
                    mem_write_q    <= 1'b1;
                    mem_write_data <= st_data;
                end else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= wr_q ? 32'd0 : ld_data;
                end
                MERGE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a word memory model
module tb_load_store_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_write = 0;
    logic [1:0]  req_size = 0;
    logic        req_unsigned = 0;
    logic [31:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:127];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int acc_cnt = 0;
    logic both_seen = 0;
    logic [31:0] last_wdata = 0;
    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[6:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[6:0]] <= mem_write_data;
            last_wdata <= mem_write_data;
        end
        rd_cnt <= rd_cnt + int'(mem_read);
        wr_cnt <= wr_cnt + int'(mem_write);
        acc_cnt <= acc_cnt + int'(req_valid && req_ready);
        if (mem_read && mem_write) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_er, input int exp_nrd, input int exp_nwr);
        int lat, r0, w0;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0; rd = 0; er = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                rd = resp_rdata;
                er = resp_error;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, 32'(er), 32'(exp_er));
        check({tag, ".nread"}, 32'(rd_cnt - r0), 32'(exp_nrd));
        check({tag, ".nwrite"}, 32'(wr_cnt - w0), 32'(exp_nwr));
    endtask

    initial begin
        int w0, r0, a0;
        for (int i = 0; i < 128; i++) mem[i] = 0;
        mem[0] = 3; mem[1] = 4; mem[2] = 10; mem[3] = 28; mem[4] = 5; mem[5] = 20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_error", 32'(resp_error), 32'd0);
        check("rst.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.addr", mem_address, 32'd0);
        check("rst.wdata", mem_write_data, 32'd0);
        rst = 0;

        // LW 8 with explicit check of the access cycle
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 8;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        check("lw8.acc_read", 32'(mem_read), 32'd1);
        check("lw8.acc_addr", mem_address, 32'd2);
        @(negedge clk);
        check("lw8.resp_valid", 32'(resp_valid), 32'd1);
        check("lw8.rdata", resp_rdata, 32'd10);
        check("lw8.err", 32'(resp_error), 32'd0);

        run("lw8", 0, 2'b10, 0, 8, 0, 2, 10, 0, 1, 0);
        run("sb13", 1, 2'b00, 0, 13, 32'h80, 3, 0, 0, 1, 1);
        check("sb13.wdata", last_wdata, 32'h0000_801c);
        check("sb13.mem", mem[3], 32'h0000_801c);
        run("lb13", 0, 2'b00, 0, 13, 0, 2, 32'hffff_ff80, 0, 1, 0);
        run("lbu13", 0, 2'b00, 1, 13, 0, 2, 32'h0000_0080, 0, 1, 0);
        run("sh22", 1, 2'b01, 0, 22, 32'h0000_beef, 3, 0, 0, 1, 1);
        check("sh22.mem", mem[5], 32'hbeef_0014);
        run("lh22", 0, 2'b01, 0, 22, 0, 2, 32'hffff_beef, 0, 1, 0);
        run("lhu22", 0, 2'b01, 1, 22, 0, 2, 32'h0000_beef, 0, 1, 0);
        run("sw0", 1, 2'b10, 0, 0, 32'h1234_5678, 2, 0, 0, 0, 1);
        check("sw0.mem", mem[0], 32'h1234_5678);
        run("lb0", 0, 2'b00, 1, 0, 0, 2, 32'h78, 0, 1, 0);
        run("lb3", 0, 2'b00, 0, 3, 0, 2, 32'h12, 0, 1, 0);
        run("lw6", 0, 2'b10, 0, 6, 0, 1, 0, 1, 0, 0);
        run("lh3", 0, 2'b01, 0, 3, 0, 1, 0, 1, 0, 0);
        run("sz11", 0, 2'b11, 0, 0, 0, 1, 0, 1, 0, 0);
        run("lw512", 0, 2'b10, 0, 512, 0, 1, 0, 1, 0, 0);
        run("sw512", 1, 2'b10, 0, 512, 32'hdead_beef, 1, 0, 1, 0, 0);
        run("lw508", 0, 2'b10, 0, 508, 0, 2, 0, 0, 1, 0);

        // reset asserted during the MERGE cycle of SB 13
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 13; req_wdata = 32'h55;
        w0 = wr_cnt; r0 = rd_cnt;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstm.ready", 32'(req_ready), 32'd1);
        check("rstm.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("rstm.ready2", 32'(req_ready), 32'd1);
        check("rstm.resp_valid2", 32'(resp_valid), 32'd0);
        check("rstm.mem", mem[3], 32'h0000_801c);
        check("rstm.nwrite", 32'(wr_cnt - w0), 32'd0);
        check("rstm.nread", 32'(rd_cnt - r0), 32'd1);

        // req_valid held through a busy sub-word store
        @(negedge clk);
        a0 = acc_cnt;
        req_valid = 1; req_write = 1; req_size = 2'b00; req_addr = 17; req_wdata = 32'h11;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("hold.ready%0d", i), 32'(req_ready), 32'd0);
        end
        check("hold.resp_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        req_valid = 0;
        check("hold.ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("hold.accepts", 32'(acc_cnt - a0), 32'd1);
        check("hold.mem", mem[4], 32'h0000_1105);
        check("strobe_excl", 32'(both_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
